// File: rtl/execute_memory_pkg.sv
// execute_memory_pkg
// ------------------
// Shared definitions for the execute/memory pipeline slice.
//
// Contents:
//   - alu_op_e       : ALU control encodings carried on DX_ALUctr.
//   - DM_DEPTH/DM_AW : data memory geometry (words / word-address width).
//   - xm_reg_t       : contents of the EX->MEM pipeline register.
//   - alu_compute()  : combinational ALU used by the EX stage.
//   - sat_inc16()    : saturating 16-bit increment for the retire counters.
package execute_memory_pkg;

  // ALU control encodings. Codes 3..7 are reserved and yield zero.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLT = 3'd2
  } alu_op_e;

  // Data memory geometry: 64 words of 32 bits, addressed by byte bits [7:2].
  localparam int DM_DEPTH = 64;
  localparam int DM_AW    = 6;

  // Everything the MEM stage needs about one instruction.
  typedef struct packed {
    logic [31:0] alu_out;
    logic [4:0]  rd;
    logic        lw;
    logic        sw;
    logic [31:0] sw_data;
  } xm_reg_t;

  // EX-stage ALU. Add and sub wrap modulo 2^32; slt is a signed compare.
  // Reserved codes return zero so that garbage control never leaks data.
  function automatic logic [31:0] alu_compute(input logic [2:0]  ctr,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] res;
    res = 32'd0;
    case (ctr)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/data_memory.sv
// data_memory
// -----------
// 64 x 32 data memory for the MEM stage. Writes happen on the rising clock
// edge; the read port is purely combinational, so a read in the same cycle
// as a write sees the old contents and a read on any later cycle sees the
// new ones. Asserting reset clears every word asynchronously.
//
// Ports:
//   clk   : in  - system clock, writes on rising edge
//   rst   : in  - asynchronous active-low reset, clears all words
//   we    : in  - write enable
//   addr  : in  - word index [DM_AW-1:0], shared by read and write
//   wdata : in  - 32-bit write data
//   rdata : out - 32-bit combinational read data at addr
module data_memory
  import execute_memory_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DM_AW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DM_DEPTH];

  // Storage array. Clearing on reset means a load after reset never
  // observes stale data from before it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DM_DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Asynchronous read so the MEM stage can register the loaded word on the
  // same edge that retires the instruction.
  assign rdata = mem[addr];

endmodule

// File: rtl/execute_memory.sv
// execute_memory
// --------------
// Two-stage execute/memory pipeline slice. An instruction presented on the
// DX_* inputs is captured into the XM register on the next rising edge (EX)
// and retired into the MW register on the following edge (MEM), giving a
// fixed two-clock latency with one instruction accepted per cycle.
//
// Ports:
//   clk       : in  - system clock
//   rst       : in  - asynchronous active-low reset
//   DX_A      : in  - ALU operand A (base register for lw/sw)
//   DX_B      : in  - ALU operand B (register or extended immediate)
//   DX_RD     : in  - destination register, ignored for stores
//   DX_ALUctr : in  - 0 add, 1 sub, 2 slt, others reserved (result 0)
//   DX_lwFlag : in  - instruction is a load
//   DX_swFlag : in  - instruction is a store (wins over lwFlag)
//   DX_swData : in  - store data
//   MW_RD     : out - write-back register, 0 means no write
//   MW_ALUout : out - write-back data (load data, ALU result or store address)
//   lw_cnt    : out - retired loads, saturating
//   sw_cnt    : out - retired stores, saturating
module execute_memory
  import execute_memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DX_A,
  input  logic [31:0] DX_B,
  input  logic [4:0]  DX_RD,
  input  logic [2:0]  DX_ALUctr,
  input  logic        DX_lwFlag,
  input  logic        DX_swFlag,
  input  logic [31:0] DX_swData,
  output logic [4:0]  MW_RD,
  output logic [31:0] MW_ALUout,
  output logic [15:0] lw_cnt,
  output logic [15:0] sw_cnt
);

  logic [31:0]      ex_result;
  xm_reg_t          xm;
  logic             mem_is_sw;
  logic             mem_is_lw;
  logic [DM_AW-1:0] mem_index;
  logic [31:0]      mem_rdata;

  // EX stage: pure combinational ALU on the incoming operands.
  always_comb begin
    ex_result = alu_compute(DX_ALUctr, DX_A, DX_B);
  end

  // XM pipeline register. Clearing it on reset turns whatever was in flight
  // into a harmless add to r0, so a store caught here never commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xm <= '0;
    end else begin
      xm.alu_out <= ex_result;
      xm.rd      <= DX_RD;
      xm.lw      <= DX_lwFlag;
      xm.sw      <= DX_swFlag;
      xm.sw_data <= DX_swData;
    end
  end

  // MEM stage decode. A store takes priority when both flags are set.
  // Only byte-address bits [7:2] index the memory, so addresses wrap every
  // 256 bytes and the low two bits never cause a fault.
  always_comb begin
    mem_is_sw = xm.sw;
    mem_is_lw = xm.lw & ~xm.sw;
    mem_index = xm.alu_out[7:2];
  end

  data_memory u_data_memory (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_is_sw),
    .addr  (mem_index),
    .wdata (xm.sw_data),
    .rdata (mem_rdata)
  );

  // MW pipeline register. Stores suppress write-back but still expose their
  // effective address; loads return the memory word, which already reflects
  // a store retired on the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MW_RD     <= 5'd0;
      MW_ALUout <= 32'd0;
    end else if (mem_is_sw) begin
      MW_RD     <= 5'd0;
      MW_ALUout <= xm.alu_out;
    end else if (mem_is_lw) begin
      MW_RD     <= xm.rd;
      MW_ALUout <= mem_rdata;
    end else begin
      MW_RD     <= xm.rd;
      MW_ALUout <= xm.alu_out;
    end
  end

  // Retire counters, bumped as each load or store leaves MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lw_cnt <= 16'd0;
      sw_cnt <= 16'd0;
    end else begin
      if (mem_is_lw) begin
        lw_cnt <= sat_inc16(lw_cnt);
      end
      if (mem_is_sw) begin
        sw_cnt <= sat_inc16(sw_cnt);
      end
    end
  end

endmodule

// File: tb/tb_execute_memory.sv
// tb_execute_memory
// -----------------
// Directed-vector bench for execute_memory. Inputs change one time unit
// after a rising edge and outputs are sampled at the same offset, well away
// from the active edge. Each expected value below is worked out by hand.
module tb_execute_memory;

  logic        clk;
  logic        rst;
  logic [31:0] DX_A;
  logic [31:0] DX_B;
  logic [4:0]  DX_RD;
  logic [2:0]  DX_ALUctr;
  logic        DX_lwFlag;
  logic        DX_swFlag;
  logic [31:0] DX_swData;
  logic [4:0]  MW_RD;
  logic [31:0] MW_ALUout;
  logic [15:0] lw_cnt;
  logic [15:0] sw_cnt;

  int testsRun;
  int testsFailed;

  execute_memory dut (
    .clk       (clk),
    .rst       (rst),
    .DX_A      (DX_A),
    .DX_B      (DX_B),
    .DX_RD     (DX_RD),
    .DX_ALUctr (DX_ALUctr),
    .DX_lwFlag (DX_lwFlag),
    .DX_swFlag (DX_swFlag),
    .DX_swData (DX_swData),
    .MW_RD     (MW_RD),
    .MW_ALUout (MW_ALUout),
    .lw_cnt    (lw_cnt),
    .sw_cnt    (sw_cnt)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction and let one rising edge capture it; returns
  // one time unit after that edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [2:0] ctr,
                               input logic lw, input logic sw,
                               input logic [31:0] data);
    DX_A      = a;
    DX_B      = b;
    DX_RD     = rd;
    DX_ALUctr = ctr;
    DX_lwFlag = lw;
    DX_swFlag = sw;
    DX_swData = data;
    @(posedge clk);
    #1;
  endtask

  // A bubble: add 0+0 into r0.
  task automatic applyNop();
    applyStimulus(32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b0;
    DX_A        = 32'd0;
    DX_B        = 32'd0;
    DX_RD       = 5'd0;
    DX_ALUctr   = 3'd0;
    DX_lwFlag   = 1'b0;
    DX_swFlag   = 1'b0;
    DX_swData   = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mw_rd", {27'd0, MW_RD}, 32'd0);
    checkOutput("reset_mw_aluout", MW_ALUout, 32'd0);
    checkOutput("reset_lw_cnt", {16'd0, lw_cnt}, 32'd0);
    checkOutput("reset_sw_cnt", {16'd0, sw_cnt}, 32'd0);
    rst = 1'b1;

    // add 5+7 -> r3: not visible after one edge, visible after two.
    applyStimulus(32'd5, 32'd7, 5'd3, 3'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("add_not_early", {27'd0, MW_RD}, 32'd0);
    applyNop();
    checkOutput("add_rd", {27'd0, MW_RD}, 32'd3);
    checkOutput("add_result", MW_ALUout, 32'd12);

    // sub 1-2 wraps to all ones.
    applyStimulus(32'd1, 32'd2, 5'd4, 3'd1, 1'b0, 1'b0, 32'd0);
    applyNop();
    checkOutput("sub_rd", {27'd0, MW_RD}, 32'd4);
    checkOutput("sub_wrap", MW_ALUout, 32'hFFFFFFFF);

    // slt is signed: -1 < 1 true, 1 < -1 false. Issued back to back.
    applyStimulus(32'hFFFFFFFF, 32'd1, 5'd5, 3'd2, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'd1, 32'hFFFFFFFF, 5'd6, 3'd2, 1'b0, 1'b0, 32'd0);
    checkOutput("slt_true", MW_ALUout, 32'd1);
    applyNop();
    checkOutput("slt_false", MW_ALUout, 32'd0);
    checkOutput("slt_false_rd", {27'd0, MW_RD}, 32'd6);

    // Reserved control code yields zero; rd still passes through.
    applyStimulus(32'd3, 32'd4, 5'd7, 3'd5, 1'b0, 1'b0, 32'd0);
    applyNop();
    checkOutput("reserved_result", MW_ALUout, 32'd0);
    checkOutput("reserved_rd", {27'd0, MW_RD}, 32'd7);

    // Destination r0 stays r0.
    applyStimulus(32'd10, 32'd20, 5'd0, 3'd0, 1'b0, 1'b0, 32'd0);
    applyNop();
    checkOutput("rd0_rd", {27'd0, MW_RD}, 32'd0);
    checkOutput("rd0_result", MW_ALUout, 32'd30);

    // sw [16+4] = DEADBEEF, then lw r9 <- [20+0] immediately after.
    applyStimulus(32'd16, 32'd4, 5'd2, 3'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    applyStimulus(32'd20, 32'd0, 5'd9, 3'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("sw_rd", {27'd0, MW_RD}, 32'd0);
    checkOutput("sw_addr", MW_ALUout, 32'd20);
    applyNop();
    checkOutput("lw_rd", {27'd0, MW_RD}, 32'd9);
    checkOutput("lw_forward", MW_ALUout, 32'hDEADBEEF);
    checkOutput("lw_cnt_1", {16'd0, lw_cnt}, 32'd1);
    checkOutput("sw_cnt_1", {16'd0, sw_cnt}, 32'd1);

    // Address 0x103 lands on word 0; a load from 0x000 sees it.
    applyStimulus(32'h100, 32'd3, 5'd0, 3'd0, 1'b0, 1'b1, 32'hA5);
    applyStimulus(32'd0, 32'd0, 5'd10, 3'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_sw_addr", MW_ALUout, 32'h103);
    applyNop();
    checkOutput("wrap_lw", MW_ALUout, 32'hA5);
    checkOutput("lw_cnt_2", {16'd0, lw_cnt}, 32'd2);
    checkOutput("sw_cnt_2", {16'd0, sw_cnt}, 32'd2);

    // Store to 8 caught in XM by reset: it must never commit.
    applyStimulus(32'd8, 32'd0, 5'd0, 3'd0, 1'b0, 1'b1, 32'h12345678);
    DX_swFlag = 1'b0;
    DX_swData = 32'd0;
    DX_A      = 32'd0;
    rst       = 1'b0;
    #2;
    checkOutput("midreset_lw_cnt", {16'd0, lw_cnt}, 32'd0);
    checkOutput("midreset_sw_cnt", {16'd0, sw_cnt}, 32'd0);
    checkOutput("midreset_mw_aluout", MW_ALUout, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(32'd8, 32'd0, 5'd11, 3'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(32'd0, 32'd0, 5'd12, 3'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("midreset_lw8_rd", {27'd0, MW_RD}, 32'd11);
    checkOutput("midreset_lw8", MW_ALUout, 32'd0);
    applyNop();
    checkOutput("midreset_lw0_cleared", MW_ALUout, 32'd0);
    checkOutput("post_reset_lw_cnt", {16'd0, lw_cnt}, 32'd2);
    checkOutput("post_reset_sw_cnt", {16'd0, sw_cnt}, 32'd0);

    // Both flags set: behaves as a store, only sw_cnt moves.
    applyStimulus(32'h40, 32'd0, 5'd13, 3'd0, 1'b1, 1'b1, 32'd77);
    applyStimulus(32'h40, 32'd0, 5'd14, 3'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("both_rd", {27'd0, MW_RD}, 32'd0);
    checkOutput("both_addr", MW_ALUout, 32'h40);
    checkOutput("both_lw_cnt", {16'd0, lw_cnt}, 32'd2);
    checkOutput("both_sw_cnt", {16'd0, sw_cnt}, 32'd1);
    applyNop();
    checkOutput("both_stored", MW_ALUout, 32'd77);
    checkOutput("both_then_lw_cnt", {16'd0, lw_cnt}, 32'd3);

    // 65540 more loads push lw_cnt past the top; it must stick at FFFF.
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(32'd0, 32'd0, 5'd1, 3'd0, 1'b1, 1'b0, 32'd0);
    end
    applyNop();
    applyNop();
    checkOutput("lw_cnt_saturated", {16'd0, lw_cnt}, 32'h0000FFFF);
    checkOutput("sw_cnt_after_sat", {16'd0, sw_cnt}, 32'd1);

    // A saturated lw_cnt does not stop sw_cnt from counting.
    applyStimulus(32'd4, 32'd0, 5'd0, 3'd0, 1'b1, 1'b1, 32'd1);
    applyNop();
    checkOutput("sat_both_lw_cnt", {16'd0, lw_cnt}, 32'h0000FFFF);
    checkOutput("sat_both_sw_cnt", {16'd0, sw_cnt}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
